// File: rtl/mcn_bank_arbiter_if.sv
// mcn_bank_arbiter_if: requester-side and data_mem-side buses of the bank arbiter.
interface mcn_bank_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 32
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    rw;
    logic [NREQ*9-1:0]  addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    ack;
    logic [DW-1:0]      rdata;
    logic [2:0]         grant_id;
    logic               busy;
    logic               halt;
    logic               reqMEM;
    logic               rwMEM;
    logic [2:0]         bankSelect;
    logic [5:0]         addrMEM;
    logic [DW-1:0]      doutMEM;
    logic [DW-1:0]      dinMEM;
    logic               ready;
    logic               ackMEM;

    modport slave (
        input  req, rw, addr, wdata, dinMEM, ready, ackMEM,
        output ack, rdata, grant_id, busy, halt, reqMEM, rwMEM, bankSelect, addrMEM, doutMEM
    );

    modport master (
        output req, rw, addr, wdata, dinMEM, ready, ackMEM,
        input  ack, rdata, grant_id, busy, halt, reqMEM, rwMEM, bankSelect, addrMEM, doutMEM
    );
endinterface

// File: rtl/mcn_bank_arbiter.sv
// mcn_bank_arbiter: round-robin sequencer sharing one data_mem port among NREQ requesters.
module mcn_bank_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input logic             clk,
    input logic             reset,
    mcn_bank_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, HALT} state_t;
    state_t            state, state_d;
    logic [7:0]        cnt, cnt_d, cnt_inc;
    logic [2:0]        ptr, ptr_d, id, id_d, win;
    logic              lrw, lrw_d;
    logic [8:0]        la, la_d;
    logic [DW-1:0]     lwd, lwd_d;
    logic [NREQ-1:0]   ack_d;
    logic [DW-1:0]     rdata_d, dout_d;
    logic [2:0]        grant_d, bank_d;
    logic [5:0]        addr_d;
    logic              busy_d, halt_d, req_mem_d, rw_mem_d, tmo;
    logic [2*NREQ-1:0] dbl;
    logic [3:0]        off, sum;

    // rotate requests so bit 0 is the requester just after ptr, then take the lowest set bit
    always_comb begin
        dbl = {bus.req, bus.req} >> (ptr + 3'd1);
        off = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (dbl[k]) off = 4'(k);
        sum = 4'(ptr) + 4'd1 + off;
        win = 3'(sum >= 4'(NREQ) ? sum - 4'(NREQ) : sum);
    end

    assign cnt_inc = cnt + 8'd1;
    assign tmo     = cnt_inc == 8'(TIMEOUT);

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        ptr_d     = ptr;
        id_d      = id;
        lrw_d     = lrw;
        la_d      = la;
        lwd_d     = lwd;
        ack_d     = '0;
        rdata_d   = bus.rdata;
        grant_d   = bus.grant_id;
        halt_d    = bus.halt;
        req_mem_d = bus.reqMEM;
        rw_mem_d  = bus.rwMEM;
        bank_d    = bus.bankSelect;
        addr_d    = bus.addrMEM;
        dout_d    = bus.doutMEM;
        case (state)
            IDLE: if (|bus.req) begin
                state_d = ISSUE;
                id_d    = win;
                grant_d = win;
                lrw_d   = bus.rw[win];
                la_d    = bus.addr[9*win +: 9];
                lwd_d   = bus.wdata[DW*win +: DW];
                cnt_d   = '0;
            end
            ISSUE: begin
                cnt_d = cnt_inc;
                if (tmo) begin
                    state_d   = HALT;
                    halt_d    = 1'b1;
                    req_mem_d = 1'b0;
                end else if (bus.ready) begin
                    state_d   = WAIT;
                    req_mem_d = 1'b1;
                    rw_mem_d  = lrw;
                    bank_d    = la[8:6];
                    addr_d    = la[5:0];
                    dout_d    = lwd;
                end
            end
            WAIT: if (bus.ackMEM) begin
                state_d   = RESP;
                req_mem_d = 1'b0;
                ack_d     = NREQ'(1) << id;
                rdata_d   = lrw ? bus.rdata : bus.dinMEM;
            end else begin
                cnt_d = cnt_inc;
                if (tmo) begin
                    state_d   = HALT;
                    halt_d    = 1'b1;
                    req_mem_d = 1'b0;
                end
            end
            RESP: begin
                state_d = IDLE;
                ptr_d   = id;
            end
            default: ;
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= '0;
            ptr            <= 3'(NREQ - 1);
            id             <= '0;
            lrw            <= 1'b0;
            la             <= '0;
            lwd            <= '0;
            bus.ack        <= '0;
            bus.rdata      <= '0;
            bus.grant_id   <= '0;
            bus.busy       <= 1'b0;
            bus.halt       <= 1'b0;
            bus.reqMEM     <= 1'b0;
            bus.rwMEM      <= 1'b0;
            bus.bankSelect <= '0;
            bus.addrMEM    <= '0;
            bus.doutMEM    <= '0;
        end else begin
            state          <= state_d;
            cnt            <= cnt_d;
            ptr            <= ptr_d;
            id             <= id_d;
            lrw            <= lrw_d;
            la             <= la_d;
            lwd            <= lwd_d;
            bus.ack        <= ack_d;
            bus.rdata      <= rdata_d;
            bus.grant_id   <= grant_d;
            bus.busy       <= busy_d;
            bus.halt       <= halt_d;
            bus.reqMEM     <= req_mem_d;
            bus.rwMEM      <= rw_mem_d;
            bus.bankSelect <= bank_d;
            bus.addrMEM    <= addr_d;
            bus.doutMEM    <= dout_d;
        end
    end
endmodule

// File: tb/tb_mcn_bank_arbiter.sv
// tb_mcn_bank_arbiter: directed tests with a transaction-level reference model of the arbiter.
module tb_mcn_bank_arbiter;
    localparam int NREQ    = 4;
    localparam int DW      = 32;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    bit   mem_auto = 1'b1;
    logic [31:0] mem_data = 32'hDEADBEEF;
    int   ack_log[$];

    mcn_bank_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();
    mcn_bank_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // memory acknowledges in the first cycle it sees reqMEM when mem_auto is set
    always @(negedge clk) begin
        bus.ackMEM = mem_auto && bus.reqMEM;
        bus.dinMEM = mem_data;
    end

    // reference model: rotating-priority pick, one transaction at a time, timeout by age
    logic [3:0]  e_ack;
    logic [31:0] e_rdata, e_dout;
    logic [2:0]  e_grant, e_bank;
    logic [5:0]  e_addr;
    logic        e_busy, e_halt, e_req, e_rw;
    int          rr_last, age, t_id;
    bit          halted, in_txn, outstanding, resp_pending, t_rw;
    logic [8:0]  t_a;
    logic [31:0] t_wd;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            {e_ack, e_rdata, e_dout, e_grant, e_bank, e_addr} = '0;
            {e_busy, e_halt, e_req, e_rw} = '0;
            {halted, in_txn, outstanding, resp_pending} = '0;
            rr_last = NREQ - 1;
            age = 0;
        end else begin
            e_ack = '0;
            if (halted) begin
            end else if (resp_pending) begin
                resp_pending = 0;
                in_txn = 0;
                rr_last = t_id;
            end else if (!in_txn) begin
                for (int k = 1; k <= NREQ; k++)
                    if (!in_txn && bus.req[(rr_last + k) % NREQ]) begin
                        t_id = (rr_last + k) % NREQ;
                        t_rw = bus.rw[t_id];
                        t_a = bus.addr[9*t_id +: 9];
                        t_wd = bus.wdata[32*t_id +: 32];
                        e_grant = 3'(t_id);
                        in_txn = 1;
                        age = 0;
                    end
            end else begin
                age++;
                if (outstanding && bus.ackMEM) begin
                    outstanding = 0;
                    e_req = 0;
                    if (!t_rw) e_rdata = bus.dinMEM;
                    e_ack = 4'(1 << t_id);
                    resp_pending = 1;
                end else if (age == TIMEOUT) begin
                    halted = 1;
                    e_halt = 1;
                    e_req = 0;
                    outstanding = 0;
                end else if (!outstanding && bus.ready) begin
                    outstanding = 1;
                    e_req = 1;
                    e_rw = t_rw;
                    e_bank = t_a[8:6];
                    e_addr = t_a[5:0];
                    e_dout = t_wd;
                end
            end
            e_busy = halted || in_txn;
        end
    end

    always @(posedge clk) begin
        #1;
        if (reset) begin
            chk("ack", 64'(bus.ack), 64'(e_ack));
            chk("rdata", 64'(bus.rdata), 64'(e_rdata));
            chk("grant_id", 64'(bus.grant_id), 64'(e_grant));
            chk("busy", 64'(bus.busy), 64'(e_busy));
            chk("halt", 64'(bus.halt), 64'(e_halt));
            chk("reqMEM", 64'(bus.reqMEM), 64'(e_req));
            if (e_req) begin
                chk("rwMEM", 64'(bus.rwMEM), 64'(e_rw));
                chk("bankSelect", 64'(bus.bankSelect), 64'(e_bank));
                chk("addrMEM", 64'(bus.addrMEM), 64'(e_addr));
                chk("doutMEM", 64'(bus.doutMEM), 64'(e_dout));
            end
            for (int i = 0; i < NREQ; i++)
                if (bus.ack[i]) ack_log.push_back(i);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(int i, bit rw, logic [8:0] a, logic [31:0] wd);
        bus.rw[i] = rw;
        bus.addr[9*i +: 9] = a;
        bus.wdata[32*i +: 32] = wd;
    endtask

    task automatic wait_acks(int n, int lim);
        int c = 0;
        while (ack_log.size() < n && c < lim) begin
            tick();
            c++;
        end
        chk("ack_wait", 64'(ack_log.size() >= n), 64'd1);
    endtask

    task automatic wait_reqmem(int lim);
        int c = 0;
        while (!bus.reqMEM && c < lim) begin
            tick();
            c++;
        end
        chk("reqMEM_wait", 64'(bus.reqMEM), 64'd1);
    endtask

    task automatic chk_zero(string nm);
        chk(nm, {bus.ack, bus.grant_id, bus.busy, bus.halt, bus.reqMEM, bus.rwMEM,
                 bus.bankSelect, bus.addrMEM}, 64'd0);
        chk(nm, {bus.rdata, bus.doutMEM}, 64'd0);
    endtask

    initial begin
        int exp_rr[8] = '{0, 1, 2, 3, 0, 1, 3, 1};
        int n;
        bus.req = '0;
        bus.rw = '0;
        bus.addr = '0;
        bus.wdata = '0;
        bus.ready = 1'b1;
        repeat (2) tick();
        chk_zero("reset_state");

        // single read
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        set_req(2, 1'b0, 9'h0C5, 32'h0);
        bus.req = 4'b0100;
        tick();
        chk("rd_grant", 64'(bus.grant_id), 64'd2);
        chk("rd_busy", 64'(bus.busy), 64'd1);
        tick();
        chk("rd_mem", {bus.reqMEM, bus.rwMEM, bus.bankSelect, bus.addrMEM}, {1'b1, 1'b0, 3'd3, 6'h05});
        tick();
        chk("rd_ack", 64'(bus.ack), 64'b0100);
        chk("rd_rdata", 64'(bus.rdata), 64'hDEADBEEF);
        @(negedge clk);
        bus.req = '0;
        tick();
        chk("rd_ack_clear", {bus.ack, bus.busy}, 64'd0);

        // round-robin from reset
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 9'(i * 9 + 1), 32'h0);
        bus.req = 4'hF;
        @(negedge clk);
        reset = 1'b1;
        ack_log.delete();
        wait_acks(5, 40);
        @(negedge clk);
        bus.req = 4'b1010;
        wait_acks(8, 40);
        @(negedge clk);
        bus.req = '0;
        for (int i = 0; i < 8 && i < ack_log.size(); i++)
            chk($sformatf("rr_grant%0d", i), 64'(ack_log[i]), 64'(exp_rr[i]));

        // write keeps rdata
        repeat (2) tick();
        @(negedge clk);
        mem_data = 32'hCAFEF00D;
        set_req(0, 1'b1, 9'h1FF, 32'h12345678);
        bus.req = 4'b0001;
        ack_log.delete();
        wait_reqmem(10);
        chk("wr_mem", {bus.rwMEM, bus.bankSelect, bus.addrMEM, bus.doutMEM},
            {1'b1, 3'd7, 6'd63, 32'h12345678});
        wait_acks(1, 10);
        chk("wr_rdata_held", 64'(bus.rdata), 64'hDEADBEEF);
        @(negedge clk);
        bus.req = '0;

        // ready stall
        repeat (2) tick();
        @(negedge clk);
        set_req(1, 1'b0, 9'h042, 32'h0);
        bus.req = 4'b0010;
        bus.ready = 1'b0;
        tick();
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("stall_reqMEM%0d", i), 64'(bus.reqMEM), 64'd0);
        end
        @(negedge clk);
        bus.ready = 1'b1;
        tick();
        chk("stall_rise", {bus.reqMEM, bus.halt}, 64'b10);
        ack_log.delete();
        wait_acks(1, 10);
        @(negedge clk);
        bus.req = '0;

        // timeout
        repeat (2) tick();
        @(negedge clk);
        mem_auto = 1'b0;
        set_req(3, 1'b0, 9'h003, 32'h0);
        bus.req = 4'b1000;
        ack_log.delete();
        tick();
        n = 0;
        while (!bus.halt && n < 40) begin
            tick();
            n++;
        end
        chk("tmo_cycles", 64'(n), 64'd15);
        chk("tmo_outs", {bus.halt, bus.reqMEM, bus.ack}, {1'b1, 1'b0, 4'b0});
        @(negedge clk);
        bus.req = 4'hF;
        repeat (5) tick();
        chk("halt_sticky", {bus.busy, bus.halt, bus.reqMEM}, 64'b110);
        chk("halt_no_ack", 64'(ack_log.size()), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_zero("halt_reset");

        // reset mid-WAIT
        @(negedge clk);
        bus.req = '0;
        reset = 1'b1;
        @(negedge clk);
        set_req(2, 1'b0, 9'h011, 32'h0);
        bus.req = 4'b0100;
        wait_reqmem(10);
        #2;
        reset = 1'b0;
        #1;
        chk_zero("async_reset");
        @(negedge clk);
        mem_auto = 1'b1;
        set_req(0, 1'b0, 9'h020, 32'h0);
        set_req(3, 1'b0, 9'h030, 32'h0);
        bus.req = 4'b1001;
        ack_log.delete();
        reset = 1'b1;
        wait_acks(1, 10);
        @(negedge clk);
        bus.req = 4'b1000;
        wait_acks(2, 10);
        @(negedge clk);
        bus.req = '0;
        if (ack_log.size() >= 2) begin
            chk("post_reset_first", 64'(ack_log[0]), 64'd0);
            chk("post_reset_second", 64'(ack_log[1]), 64'd3);
        end
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/mcn_bank_arbiter.md
Name: mcn_bank_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single data-memory port (bank select plus bank address) between NREQ requesters, e.g. multiple MAU lanes.
- Sits between the requesters and data_mem, and replaces the direct mcn-to-memory path when more than one requester is present.
- Serialises transactions with one outstanding access at a time.
- Raises a sticky halt when memory fails to acknowledge within TIMEOUT cycles.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 32, data width.
- TIMEOUT, 15, maximum cycles in ISSUE+WAIT before halt (1..255).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  NREQ  per-requester request; held high until its ack.
- rw  input  NREQ  per-requester direction; 1 = write, 0 = read.
- addr  input  NREQ*9  flattened; requester i at bits [9i+8:9i]; [8:6] = bank, [5:0] = word.
- wdata  input  NREQ*DW  flattened write data; requester i at bits [DW*i+DW-1:DW*i].
- ack  output  NREQ  one-cycle completion pulse to the granted requester.
- rdata  output  DW  read data; valid while ack is high, then held.
- grant_id  output  3  index of the current or last granted requester.
- busy  output  1  high in every state except IDLE.
- halt  output  1  sticky memory-timeout flag.
- reqMEM  output  1  request to data_mem.
- rwMEM  output  1  direction to data_mem.
- bankSelect  output  3  = latched addr[8:6].
- addrMEM  output  6  = latched addr[5:0].
- doutMEM  output  DW  write data to data_mem.
- dinMEM  input  DW  read data from data_mem; valid when ackMEM is high.
- ready  input  1  data_mem able to accept a request.
- ackMEM  input  1  data_mem transaction complete.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs go to 0 and state goes to IDLE.
  - The round-robin pointer ptr goes to NREQ-1, so requester 0 has first priority.
  - A reset during any state, including WAIT or HALT, aborts the transaction with no ack.
- All outputs are registered. The states are IDLE, ISSUE, WAIT, RESP and HALT.
- IDLE:
  - If any req bit is set, pick the winner by searching from ptr+1 upward, modulo NREQ.
  - Latch the winner's id, rw, addr and wdata, load grant_id, clear the timeout counter, and go to ISSUE.
  - With no requests, stay in IDLE.
- ISSUE:
  - If ready=1: set reqMEM=1 and drive rwMEM, bankSelect, addrMEM and doutMEM from the latched values; go to WAIT.
  - If ready=0: stay in ISSUE and increment the counter.
- WAIT:
  - Hold reqMEM and all memory fields stable; increment the counter each cycle.
  - On ackMEM=1: clear reqMEM; on a read, capture dinMEM into rdata; go to RESP.
  - On a write, rdata is unchanged.
- RESP:
  - ack[grant_id]=1 for exactly one cycle; set ptr=grant_id; go to IDLE.
  - A req still high in the following IDLE cycle is treated as a new request.
- Timeout:
  - If the counter reaches TIMEOUT in ISSUE or WAIT with no ackMEM in that cycle, go to HALT.
  - In the same edge set halt=1 and reqMEM=0; no ack is issued.
- HALT: absorbing state; requests are ignored and only reset exits it.
- An ackMEM arriving in the same cycle the counter hits TIMEOUT counts as success, not a timeout.
- Requesters:
  - Fields are sampled only in IDLE; later changes to req, rw, addr or wdata are ignored.
  - Dropping req mid-transaction does not cancel it; the ack is still pulsed.
- ackMEM seen in IDLE, ISSUE or RESP is ignored.
- Latency: with ready=1 and ackMEM returned in the first cycle reqMEM is high, req sampled at edge 0 gives ISSUE after edge 0, reqMEM after edge 1, RESP (ack high) after edge 2, and IDLE after edge 3. Throughput is one transaction per 4 cycles.
- Fairness: a continuously requesting set is served in strict rotation, with no requester starved for more than NREQ-1 transactions.

Test Plan:
- Single read: req[2]=1, rw=0, addr=9'h0C5; memory returns dinMEM=32'hDEADBEEF with ackMEM in the first reqMEM cycle. Required: bankSelect=3, addrMEM=6'h05, rwMEM=0; ack=4'b0100 for one cycle, 3 edges after sampling; rdata=32'hDEADBEEF; grant_id=2.
- Round-robin: all four requesters held high from reset. Required: grants in order 0,1,2,3,0; each ack is a single pulse; req[1] and req[3] then held high gives grants 1,3,1.
- Write: req[0]=1, rw=1, wdata=32'h12345678, addr=9'h1FF, with rdata previously 32'hDEADBEEF. Required: doutMEM=32'h12345678, bankSelect=7, addrMEM=63, rwMEM=1; rdata stays 32'hDEADBEEF.
- Ready stall: ready=0 for 5 cycles after ISSUE entry. Required: reqMEM stays 0 during the stall; reqMEM rises the edge after ready=1; no halt with TIMEOUT=15.
- Timeout: ackMEM never asserted. Required: halt=1 and reqMEM=0 once the counter reaches 15; no ack; further reqs ignored; reset=0 clears halt, busy and all outputs to 0.
- Reset mid-WAIT: assert reset while reqMEM=1. Required: all outputs 0 immediately (asynchronous); after release, a new req[3] and req[0] pair grants 0 first.
